// File: rtl/md5_nonce_scheduler.sv
// Nonce-search front end: captures a key byte stream, then offers one padded
// MD5 block (key || decimal nonce || pad || length) per nonce to the engine bank.
module md5_nonce_scheduler #(
  parameter int unsigned BLOCK_WIDTH   = 512,
  parameter int unsigned KEY_MAX_BYTES = 16,
  parameter int unsigned NONCE_DIGITS  = 8,
  parameter int unsigned COUNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   key_ready,
  input  logic                   key_valid,
  input  logic [7:0]             key_data,
  input  logic                   key_last,
  input  logic                   md5_block_ready,
  output logic                   md5_block_valid,
  output logic [BLOCK_WIDTH-1:0] md5_block_data,
  input  logic                   match_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   exhausted,
  output logic                   key_overflow,
  output logic [COUNT_WIDTH-1:0] blocks_issued
);

  if (BLOCK_WIDTH != 512) begin : g_bad_block_width
    $error("md5_nonce_scheduler: BLOCK_WIDTH must be 512");
  end
  if (KEY_MAX_BYTES + NONCE_DIGITS > 55) begin : g_bad_msg_len
    $error("md5_nonce_scheduler: KEY_MAX_BYTES+NONCE_DIGITS must be <= 55");
  end

  localparam int unsigned KLW = $clog2(KEY_MAX_BYTES + 1);
  localparam int unsigned KIW = (KEY_MAX_BYTES > 1) ? $clog2(KEY_MAX_BYTES) : 1;
  localparam int unsigned NLW = $clog2(NONCE_DIGITS + 1);
  localparam int unsigned NIW = (NONCE_DIGITS > 1) ? $clog2(NONCE_DIGITS) : 1;
  localparam logic [4*NONCE_DIGITS-1:0] NONCE_ONE = (4*NONCE_DIGITS)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  state_t                         state, state_nx;
  logic [KEY_MAX_BYTES-1:0][7:0]  key_mem;
  logic [KLW-1:0]                 key_len;
  logic [NONCE_DIGITS-1:0][3:0]   nonce, nonce_inc;
  logic [NLW-1:0]                 nonce_len, nonce_len_inc;
  logic                           exhausted_q, overflow_q;
  logic [COUNT_WIDTH-1:0]         count_q;
  logic                           key_hs, blk_hs, all_nines, is_last;
  logic [BLOCK_WIDTH-1:0]         block;

  assign key_hs = (state == S_IDLE) && key_valid;
  assign blk_hs = (state == S_RUN) && md5_block_ready;

  // BCD ripple increment; all_nines covers only the digits currently in use
  always_comb begin
    logic carry;
    carry     = 1'b1;
    all_nines = 1'b1;
    nonce_inc = nonce;
    for (int unsigned d = 0; d < NONCE_DIGITS; d++) begin
      if (d < 32'(nonce_len) && nonce[d] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (nonce[d] == 4'd9) begin
          nonce_inc[d] = 4'd0;
        end else begin
          nonce_inc[d] = nonce[d] + 4'd1;
          carry        = 1'b0;
        end
      end
    end
    nonce_len_inc = all_nines ? nonce_len + NLW'(1) : nonce_len;
    is_last       = all_nines && (nonce_len == NLW'(NONCE_DIGITS));
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (key_hs && key_last) state_nx = S_RUN;
      S_RUN: begin
        if (match_valid)          state_nx = S_DONE;
        else if (blk_hs && is_last) state_nx = S_WAIT;
      end
      S_WAIT: if (match_valid) state_nx = S_DONE;
      default: state_nx = S_DONE;
    endcase
  end

  // Block assembled purely from registered key/nonce, so data is stable under backpressure
  always_comb begin
    int unsigned kl, nl, pos;
    logic [7:0]  byte_v;
    logic [63:0] bit_len;
    block   = '0;
    kl      = 32'(key_len);
    nl      = 32'(nonce_len);
    bit_len = 64'((kl + nl) << 3);
    for (int unsigned i = 0; i < 56; i++) begin
      byte_v = 8'h00;
      pos    = 0;
      if (i < kl) begin
        byte_v = key_mem[i[KIW-1:0]];
      end else if (i < kl + nl) begin
        pos    = kl + nl - 1 - i;
        byte_v = {4'h3, nonce[pos[NIW-1:0]]};
      end else if (i == kl + nl) begin
        byte_v = 8'h80;
      end
      block[BLOCK_WIDTH-1-8*i -: 8] = byte_v;
    end
    for (int unsigned b = 0; b < 8; b++) begin
      block[BLOCK_WIDTH-1-8*(56+b) -: 8] = bit_len[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      key_mem     <= '0;
      key_len     <= '0;
      nonce       <= NONCE_ONE;
      nonce_len   <= NLW'(1);
      exhausted_q <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state <= state_nx;
      if (key_hs) begin
        if (key_len < KLW'(KEY_MAX_BYTES)) begin
          key_mem[key_len[KIW-1:0]] <= key_data;
          key_len                   <= key_len + KLW'(1);
        end else begin
          overflow_q <= 1'b1;
        end
      end
      if (blk_hs) begin
        if (is_last) begin
          exhausted_q <= 1'b1;
        end else begin
          nonce     <= nonce_inc;
          nonce_len <= nonce_len_inc;
        end
        if (count_q != '1) count_q <= count_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign key_ready       = (state == S_IDLE);
  assign md5_block_valid = (state == S_RUN);
  assign md5_block_data  = (state == S_RUN) ? block : '0;
  assign busy            = (state == S_RUN) || (state == S_WAIT);
  assign done            = (state == S_DONE);
  assign exhausted       = exhausted_q;
  assign key_overflow    = overflow_q;
  assign blocks_issued   = count_q;

endmodule

// File: tb/tb_md5_nonce_scheduler.sv
// Self-checking bench for md5_nonce_scheduler: scoreboard of expected blocks
// plus directed checks on counters, flags and the short-nonce exhaustion path.
module tb_md5_nonce_scheduler;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic         rst_a = 1'b1, key_valid_a = 1'b0, key_last_a = 1'b0;
  logic [7:0]   key_data_a = 8'h00;
  logic         ready_a = 1'b0, match_a = 1'b0;
  logic         key_ready_a, valid_a, busy_a, done_a, exh_a, ovf_a;
  logic [511:0] data_a;
  logic [31:0]  cnt_a;

  // Instance B: two-digit nonce space
  logic         rst_b = 1'b1, key_valid_b = 1'b0, key_last_b = 1'b0;
  logic [7:0]   key_data_b = 8'h00;
  logic         ready_b = 1'b0, match_b = 1'b0;
  logic         key_ready_b, valid_b, busy_b, done_b, exh_b, ovf_b;
  logic [511:0] data_b;
  logic [31:0]  cnt_b;

  md5_nonce_scheduler #(.BLOCK_WIDTH(512), .KEY_MAX_BYTES(16), .NONCE_DIGITS(8), .COUNT_WIDTH(32)) dut_a (
    .clk(clk), .reset(rst_a), .key_ready(key_ready_a), .key_valid(key_valid_a),
    .key_data(key_data_a), .key_last(key_last_a), .md5_block_ready(ready_a),
    .md5_block_valid(valid_a), .md5_block_data(data_a), .match_valid(match_a),
    .busy(busy_a), .done(done_a), .exhausted(exh_a), .key_overflow(ovf_a),
    .blocks_issued(cnt_a));

  md5_nonce_scheduler #(.BLOCK_WIDTH(512), .KEY_MAX_BYTES(16), .NONCE_DIGITS(2), .COUNT_WIDTH(32)) dut_b (
    .clk(clk), .reset(rst_b), .key_ready(key_ready_b), .key_valid(key_valid_b),
    .key_data(key_data_b), .key_last(key_last_b), .md5_block_ready(ready_b),
    .md5_block_valid(valid_b), .md5_block_data(data_b), .match_valid(match_b),
    .busy(busy_b), .done(done_b), .exhausted(exh_b), .key_overflow(ovf_b),
    .blocks_issued(cnt_b));

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  logic [511:0] sb[$];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] exp_block(input string key, input int unsigned nonce);
    logic [511:0] blk;
    logic [63:0]  bl;
    string        ns;
    int unsigned  kl, p;
    ns  = $sformatf("%0d", nonce);
    kl  = (key.len() > 16) ? 16 : key.len();
    blk = '0;
    p   = 0;
    for (int unsigned i = 0; i < kl; i++) begin
      blk[511-8*p -: 8] = key[i];
      p++;
    end
    for (int i = 0; i < ns.len(); i++) begin
      blk[511-8*p -: 8] = ns[i];
      p++;
    end
    blk[511-8*p -: 8] = 8'h80;
    bl = 64'(p * 8);
    for (int unsigned b = 0; b < 8; b++) blk[511-8*(56+b) -: 8] = bl[8*b +: 8];
    return blk;
  endfunction

  // Every handshake on instance A consumes one expected block
  always @(negedge clk) begin
    logic [511:0] e;
    if (!rst_a && valid_a && ready_a) begin
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      check("sb_block", data_a, e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key_a(input string k);
    for (int i = 0; i < k.len(); i++) begin
      key_valid_a = 1'b1;
      key_data_a  = k[i];
      key_last_a  = (i == k.len() - 1);
      tick();
    end
    key_valid_a = 1'b0;
    key_last_a  = 1'b0;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [55:0] s7;
    logic [23:0] s3;
    string       long_key;

    tick();
    check("rst_key_ready", key_ready_a, 1);
    check("rst_valid", valid_a, 0);
    check("rst_flags", {busy_a, done_a, exh_a, ovf_a}, 0);
    check("rst_count", cnt_a, 0);
    check("rst_data", data_a, 0);
    rst_a = 1'b0;

    // "abcdef": first two blocks back to back
    sb.push_back(exp_block("abcdef", 1));
    sb.push_back(exp_block("abcdef", 2));
    ready_a = 1'b1;
    send_key_a("abcdef");
    s7 = "abcdef1";
    check("first_valid", valid_a, 1);
    check("first_busy", busy_a, 1);
    check("first_text", data_a[511 -: 56], s7);
    check("first_pad", data_a[455:448], 8'h80);
    check("first_len_lsb", data_a[63:56], 8'h38);
    check("first_len_hi", data_a[55:0], 0);
    tick();
    tick();
    ready_a = 1'b0;
    check("count_two", cnt_a, 2);

    // Backpressure with nonce 3 pending
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", valid_a, 1);
      check("bp_data", data_a, exp_block("abcdef", 3));
      check("bp_count", cnt_a, 2);
      tick();
    end
    sb.push_back(exp_block("abcdef", 3));
    sb.push_back(exp_block("abcdef", 4));
    ready_a = 1'b1;
    tick();
    check("bp_release_count", cnt_a, 3);
    check("bp_next_data", data_a, exp_block("abcdef", 4));
    tick();
    ready_a = 1'b0;
    check("count_four", cnt_a, 4);

    // Match coincident with the handshake of nonce 42
    for (int unsigned n = 5; n <= 42; n++) sb.push_back(exp_block("abcdef", n));
    ready_a = 1'b1;
    repeat (37) tick();
    check("pre_match_count", cnt_a, 41);
    match_a = 1'b1;
    tick();
    match_a = 1'b0;
    check("match_count", cnt_a, 42);
    check("match_done", done_a, 1);
    check("match_valid_low", valid_a, 0);
    check("match_busy", busy_a, 0);
    match_a = 1'b1;
    repeat (3) tick();
    match_a = 1'b0;
    tick();
    check("done_count_hold", cnt_a, 42);
    check("done_sticky", done_a, 1);
    check("sb_drained_match", sb.size(), 0);
    ready_a = 1'b0;

    // "ab": nonce crosses 9 -> 10
    reset_a();
    for (int unsigned n = 1; n <= 10; n++) sb.push_back(exp_block("ab", n));
    send_key_a("ab");
    ready_a = 1'b1;
    repeat (8) tick();
    check("ab9_len", data_a[63:56], 8'h18);
    tick();
    s3 = {"10", 8'h80};
    check("ab10_len", data_a[63:56], 8'h20);
    check("ab10_text", data_a[495 -: 24], s3);
    tick();
    ready_a = 1'b0;
    check("ab_count", cnt_a, 10);
    check("sb_drained_ab", sb.size(), 0);

    // 20-byte key truncates to 16, then reset mid-run
    reset_a();
    long_key = "ABCDEFGHIJKLMNOPQRST";
    send_key_a(long_key);
    check("overflow_flag", ovf_a, 1);
    sb.push_back(exp_block(long_key, 1));
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    check("overflow_count", cnt_a, 1);
    check("sb_drained_ovf", sb.size(), 0);
    rst_a = 1'b1;
    tick();
    check("midrst_key_ready", key_ready_a, 1);
    check("midrst_valid", valid_a, 0);
    check("midrst_flags", {busy_a, done_a, exh_a, ovf_a}, 0);
    check("midrst_count", cnt_a, 0);
    rst_a = 1'b0;

    // Two-digit nonce space runs to exhaustion
    rst_b = 1'b0;
    key_valid_b = 1'b1;
    key_data_b  = "z";
    key_last_b  = 1'b1;
    tick();
    key_valid_b = 1'b0;
    key_last_b  = 1'b0;
    check("b_first_data", data_b, exp_block("z", 1));
    ready_b = 1'b1;
    for (int c = 0; c < 200 && !exh_b; c++) tick();
    check("b_exhausted", exh_b, 1);
    check("b_count", cnt_b, 99);
    check("b_wait_busy", busy_b, 1);
    check("b_wait_valid", valid_b, 0);
    check("b_not_done", done_b, 0);
    repeat (3) tick();
    check("b_count_hold", cnt_b, 99);
    match_b = 1'b1;
    tick();
    match_b = 1'b0;
    check("b_done", done_b, 1);
    check("b_done_busy", busy_b, 0);
    check("b_exh_sticky", exh_b, 1);
    ready_b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
